// File: rtl/guitar_input_conditioner.sv
// Guitar controller input conditioning: 2-flop sync + counter debounce per input, strum edge/lockout FSM.
// Optional GUITAR_INPUT_ACTIVE_LOW_EN inverts raw inputs ahead of the synchronizers.
module guitar_input_conditioner #(
  parameter int FRET_W               = 5,
  parameter int DEBOUNCE_CYCLES      = 500000,
  parameter int STRUM_LOCKOUT_CYCLES = 2500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic [FRET_W-1:0] raw_buttons,
  input  logic              raw_strum,
  output logic [FRET_W-1:0] buttons_db,
  output logic              strum_db,
  output logic              strum_pulse,
  output logic [FRET_W-1:0] frets_at_strum,
  output logic [15:0]       strum_count,
  output logic [1:0]        fsm_state
);

  localparam int CH   = FRET_W + 1;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LK_W = $clog2(STRUM_LOCKOUT_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LOAD = LK_W'(STRUM_LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKOUT = 2'd1,
    ST_RELEASE = 2'd2,
    ST_UNUSED  = 2'd3
  } state_t;

  // Channel FRET_W is the strum bar; lower channels are the frets.
  logic [CH-1:0]   raw_vec;
  logic [CH-1:0]   sync1;
  logic [CH-1:0]   sync2;
  logic [CH-1:0]   db;
  logic [DB_W-1:0] db_cnt [CH];

`ifdef GUITAR_INPUT_ACTIVE_LOW_EN
  assign raw_vec = ~{raw_strum, raw_buttons};
`else
  assign raw_vec = {raw_strum, raw_buttons};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_vec;
      sync2 <= sync1;
    end
  end

  // Any single cycle of agreement clears the count, so only a sustained change flips db.
  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < CH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign buttons_db = db[FRET_W-1:0];
  assign strum_db   = db[FRET_W];

  state_t            state;
  state_t            state_next;
  logic              strum_db_q;
  logic              pause_q;
  logic [LK_W-1:0]   lock_cnt;
  logic [LK_W-1:0]   lock_next;
  logic              pulse_next;
  logic [FRET_W-1:0] frets_next;
  logic [15:0]       count_next;
  logic              strum_rise;

  assign strum_rise = strum_db & ~strum_db_q;
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      strum_db_q     <= 1'b0;
      pause_q        <= 1'b0;
      lock_cnt       <= '0;
      strum_pulse    <= 1'b0;
      frets_at_strum <= '0;
      strum_count    <= '0;
    end else begin
      state          <= state_next;
      strum_db_q     <= strum_db;
      pause_q        <= pause;
      lock_cnt       <= lock_next;
      strum_pulse    <= pulse_next;
      frets_at_strum <= frets_next;
      strum_count    <= count_next;
    end
  end

  // A paused strum still parks in RELEASE so the held bar cannot re-trigger after unpause.
  always_comb begin
    state_next = state;
    lock_next  = lock_cnt;
    pulse_next = 1'b0;
    frets_next = frets_at_strum;
    count_next = strum_count;
    case (state)
      ST_IDLE: begin
        if (strum_rise) begin
          if (!pause_q) begin
            pulse_next = 1'b1;
            frets_next = buttons_db;
            count_next = strum_count + 16'd1;
            lock_next  = LK_LOAD;
            state_next = ST_LOCKOUT;
          end else begin
            state_next = ST_RELEASE;
          end
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt == '0) state_next = strum_db ? ST_RELEASE : ST_IDLE;
        else                lock_next  = lock_cnt - LK_W'(1);
      end
      ST_RELEASE: begin
        if (!strum_db) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
